// File: rtl/ddr_delay_eye_tracker.sv
// ddr_delay_eye_tracker: closed-loop data IDELAY centring driven by tracker probes.
// Optional: DDR_DELAY_TRACKER_STATS_EN builds the adjust_count step counter.
module ddr_delay_eye_tracker #(
  parameter int INITIAL_TAP   = 128,
  parameter int PROBE_OFFSET  = 24,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_LOG2   = 8,
  parameter int HYSTERESIS    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             data,
  input  logic [3:0]             tracker,
  output logic [1:0]             delay_config__op,
  output logic                   delay_config__select,
  output logic [8:0]             delay_config__value,
  output logic [8:0]             data_tap,
  output logic                   locked,
  output logic [WINDOW_LOG2+2:0] early_errors,
  output logic [WINDOW_LOG2+2:0] late_errors,
  output logic [15:0]            adjust_count
);

  localparam int EW = WINDOW_LOG2 + 3;
  localparam int CW = 16;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'((1 << WINDOW_LOG2) - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [9:0] TAP_MAX = 10'd511;
  localparam logic [9:0] OFFSET  = 10'(PROBE_OFFSET);
  localparam logic [EW:0] HYST   = (EW + 1)'(HYSTERESIS);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_DATA,
    LOAD_EARLY,
    SETTLE_E,
    MEASURE_E,
    LOAD_LATE,
    SETTLE_L,
    MEASURE_L,
    DECIDE,
    ADJUST
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [EW-1:0] acc;
  logic [EW-1:0] acc_sum;
  logic [3:0]    miss;
  logic [2:0]    pop;

  logic [9:0] tap_ext;
  logic [9:0] late_sum;
  logic [8:0] early_tap;
  logic [8:0] late_tap;

  logic [EW:0] early_x;
  logic [EW:0] late_x;
  logic        step_up;
  logic        step_dn;
  logic        meas;

  logic [1:0] op_nxt;
  logic       sel_nxt;
  logic [8:0] val_nxt;
  logic [8:0] tap_nxt;
  logic       locked_nxt;

  // tracker is the complemented leg, so agreement means data == ~tracker
  assign miss = data ^ ~tracker;
  assign pop  = 3'(miss[0]) + 3'(miss[1])
              + 3'(miss[2]) + 3'(miss[3]);
  assign acc_sum = acc + EW'(pop);

  // probe taps clamp at the ends of the delay line
  assign tap_ext   = {1'b0, data_tap};
  assign late_sum  = tap_ext + OFFSET;
  assign early_tap = (tap_ext >= OFFSET)
                   ? 9'(tap_ext - OFFSET) : 9'd0;
  assign late_tap  = (late_sum > TAP_MAX)
                   ? 9'd511 : late_sum[8:0];

  assign early_x = {1'b0, early_errors};
  assign late_x  = {1'b0, late_errors};

  assign meas = enable
             && ((state == MEASURE_E) || (state == MEASURE_L));

  // state register and per-state cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_ONE;
    end
  end

  // next state, tap update and the delay_config command for the next cycle
  always_comb begin
    state_nxt  = state;
    tap_nxt    = data_tap;
    locked_nxt = locked;
    op_nxt     = OP_NOP;
    sel_nxt    = 1'b0;
    val_nxt    = '0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = LOAD_DATA;
        LOAD_DATA:  state_nxt = LOAD_EARLY;
        LOAD_EARLY: state_nxt = SETTLE_E;
        SETTLE_E:
          if (cnt == SETTLE_LAST) state_nxt = MEASURE_E;
        MEASURE_E:
          if (cnt == WIN_LAST) state_nxt = LOAD_LATE;
        LOAD_LATE:  state_nxt = SETTLE_L;
        SETTLE_L:
          if (cnt == SETTLE_LAST) state_nxt = MEASURE_L;
        MEASURE_L:
          if (cnt == WIN_LAST) state_nxt = DECIDE;
        DECIDE:     state_nxt = ADJUST;
        ADJUST: begin
          state_nxt  = LOAD_DATA;
          locked_nxt = !(step_up || step_dn);
          if (step_up) tap_nxt = data_tap + 9'd1;
          else if (step_dn) tap_nxt = data_tap - 9'd1;
        end
        default:    state_nxt = IDLE;
      endcase
    end
    case (state_nxt)
      LOAD_DATA: begin
        op_nxt  = OP_LOAD;
        sel_nxt = 1'b0;
        val_nxt = tap_nxt;
      end
      LOAD_EARLY: begin
        op_nxt  = OP_LOAD;
        sel_nxt = 1'b1;
        val_nxt = early_tap;
      end
      LOAD_LATE: begin
        op_nxt  = OP_LOAD;
        sel_nxt = 1'b1;
        val_nxt = late_tap;
      end
      default: begin
        op_nxt  = OP_NOP;
        sel_nxt = 1'b0;
        val_nxt = '0;
      end
    endcase
  end

  // registered command bus, data tap and lock flag
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_config__op     <= OP_NOP;
      delay_config__select <= 1'b0;
      delay_config__value  <= '0;
      data_tap             <= 9'(INITIAL_TAP);
      locked               <= 1'b0;
    end else begin
      delay_config__op     <= op_nxt;
      delay_config__select <= sel_nxt;
      delay_config__value  <= val_nxt;
      data_tap             <= tap_nxt;
      locked               <= locked_nxt;
    end
  end

  // window accumulation; the total latches on the last window cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      early_errors <= '0;
      late_errors  <= '0;
    end else if (!meas) begin
      acc <= '0;
    end else if (cnt == WIN_LAST) begin
      acc <= '0;
      if (state == MEASURE_E) early_errors <= acc_sum;
      else late_errors <= acc_sum;
    end else begin
      acc <= acc_sum;
    end
  end

  // register the step decision so ADJUST only applies it
  always_ff @(posedge clk) begin
    if (reset) begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else if (enable && (state == DECIDE)) begin
      step_up <= (early_x > late_x + HYST)
              && (data_tap != 9'd511);
      step_dn <= (late_x > early_x + HYST)
              && (data_tap != 9'd0);
    end
  end

`ifdef DDR_DELAY_TRACKER_STATS_EN
  // count applied tap steps, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      adjust_count <= '0;
    end else if (enable && (state == ADJUST)
                 && (step_up || step_dn)
                 && (adjust_count != 16'hFFFF)) begin
      adjust_count <= adjust_count + 16'd1;
    end
  end
`else
  assign adjust_count = '0;
`endif

endmodule
